// File: rtl/generic_rom_stream_rd.sv
// Streams a {addr, len} burst out of a 1-cycle-latency ROM as a valid/ready word stream.
// Latency: command accept -> first issue +1 cycle -> first word valid +3 cycles; one word per cycle when unstalled.
// Backpressure: reads are only issued when the 2-entry buffer can absorb them, so a stalled sink never loses a word.
module generic_rom_stream_rd #(
    parameter int MEM_ADDR_BITS = 10,
    parameter int MEM_DATA_BITS = 32,
    parameter int LEN_BITS      = MEM_ADDR_BITS + 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [MEM_ADDR_BITS-1:0] i_cmd_addr,
    input  logic [LEN_BITS-1:0]      i_cmd_len,
    output logic [MEM_ADDR_BITS-1:0] o_rom_addr,
    input  logic [MEM_DATA_BITS-1:0] i_rom_data,
    output logic                     o_dat_valid,
    input  logic                     i_dat_ready,
    output logic [MEM_DATA_BITS-1:0] o_dat,
    output logic                     o_dat_last,
    output logic                     o_done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                         state, state_n;
    logic [MEM_ADDR_BITS-1:0]       addr_q, rom_addr_q;
    logic [LEN_BITS-1:0]            remaining;
    logic                           inflight, inflight_last;
    logic [1:0][MEM_DATA_BITS-1:0]  buf_dat;
    logic [1:0]                     buf_last;
    logic                           rd_ptr, wr_ptr;
    logic [1:0]                     count, count_n;
    logic [2:0]                     level;
    logic                           accept, issue, pop, push;

    assign accept      = i_cmd_valid && (state == S_IDLE);
    assign pop         = o_dat_valid && i_dat_ready;
    assign push        = inflight;
    // Words already committed to the buffer once this cycle's pop is taken out.
    assign level       = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    assign issue       = (state == S_RUN) && (remaining != '0) && (level < 3'd2);
    assign count_n     = count + {1'b0, push} - {1'b0, pop};

    assign o_cmd_ready = (state == S_IDLE);
    assign o_done      = (state == S_DONE);
    assign o_rom_addr  = issue ? addr_q : rom_addr_q;
    assign o_dat_valid = (count != 2'd0);
    assign o_dat       = buf_dat[rd_ptr];
    assign o_dat_last  = buf_last[rd_ptr] && o_dat_valid;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = (i_cmd_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (issue && (remaining == LEN_BITS'(1))) begin
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leaving on the final pop itself puts o_done one cycle after it.
                if (count_n == 2'd0) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= S_IDLE;
            addr_q        <= '0;
            rom_addr_q    <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            buf_dat       <= '0;
            buf_last      <= '0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            count         <= 2'd0;
        end else begin
            state         <= state_n;
            inflight      <= issue;
            inflight_last <= issue && (remaining == LEN_BITS'(1));
            count         <= count_n;
            if (accept) begin
                addr_q    <= i_cmd_addr;
                remaining <= i_cmd_len;
            end
            if (issue) begin
                rom_addr_q <= addr_q;
                addr_q     <= addr_q + MEM_ADDR_BITS'(1);
                remaining  <= remaining - LEN_BITS'(1);
            end
            if (push) begin
                buf_dat[wr_ptr]  <= i_rom_data;
                buf_last[wr_ptr] <= inflight_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

endmodule
